seg_serial_rx: RTL
==================

SEG_SERIAL_RX -- requirements
Module: seg_serial_rx
Receiving end of the serial display/LED shift link (clock, data, latch-enable, clear); rebuilds the parallel frame.

Interface
REQ-001 Parameter FRAME_BITS, default 64, bits per frame.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth; SHALL be >= 2.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ser_clk  input  1  serial shift clock, asynchronous to clk.
REQ-006 ser_dat  input  1  serial data, MSB first.
REQ-007 ser_pen  input  1  latch enable; low = shifting phase, rising edge = latch frame.
REQ-008 ser_clrn  input  1  active-low clear of the partial frame.
REQ-009 frame_ack  input  1  consumer acknowledge of frame_data.
REQ-010 frame_data  output  FRAME_BITS  last good frame; first received bit in MSB.
REQ-011 frame_valid  output  1  frame_data holds an unacknowledged frame.
REQ-012 frame_err  output  1  sticky; a latch occurred with wrong bit count.
REQ-013 overrun  output  1  sticky; a good frame overwrote an unacknowledged frame.
REQ-014 bit_cnt  output  $clog2(FRAME_BITS)+1  bits received in the current frame (7 bits at default).

Function
REQ-015 ser_clk, ser_dat, ser_pen and ser_clrn SHALL each pass through SYNC_STAGES flops, plus one history flop for edge detection.
REQ-016 Action on a pin edge SHALL occur SYNC_STAGES+1 clk cycles after the edge.
REQ-017 Receive FSM states: IDLE (bit_cnt=0), SHIFT (bit_cnt>0), LATCH (single cycle); LATCH always returns to IDLE.
REQ-018 Synced ser_clk rising edge with synced ser_pen low SHALL shift synced ser_dat into the shift register LSB, move older bits toward MSB, and increment bit_cnt.
REQ-019 A shift in IDLE SHALL move the FSM to SHIFT.
REQ-020 bit_cnt SHALL saturate at FRAME_BITS+1; further shifts still move data.
REQ-021 ser_clk rising edges while synced ser_pen is high SHALL be ignored.
REQ-022 Synced ser_pen rising edge in SHIFT SHALL enter LATCH.
REQ-023 Synced ser_pen rising edge in IDLE SHALL be ignored, with no error.
REQ-024 LATCH with bit_cnt=FRAME_BITS: frame_data <= shift register, frame_valid <= 1.
REQ-025 LATCH with any other bit_cnt: frame_err <= 1; frame_data and frame_valid unchanged.
REQ-026 LATCH SHALL clear bit_cnt and the shift register in every case.
REQ-027 frame_valid SHALL rise SYNC_STAGES+2 cycles after the pin ser_pen rising edge.
REQ-028 frame_ack high while frame_valid=1 SHALL clear frame_valid on the next edge.
REQ-029 frame_ack while frame_valid=0 SHALL have no effect.
REQ-030 Good LATCH while frame_valid=1 and frame_ack=0 SHALL overwrite frame_data, keep frame_valid=1 and set overrun.
REQ-031 Good LATCH in the same cycle as frame_ack SHALL load the new data, keep frame_valid=1 and leave overrun unchanged.
REQ-032 Synced ser_clrn low (level) SHALL clear the shift register and bit_cnt and force IDLE.
REQ-033 ser_clrn low SHALL take priority over shift and latch events in the same cycle and SHALL NOT affect frame_data, frame_valid or the error flags.
REQ-034 frame_err and overrun SHALL clear only on rst.

Reset
REQ-035 rst SHALL set frame_data=0, frame_valid=0, frame_err=0, overrun=0, bit_cnt=0, FSM=IDLE, and discard any partial frame.
REQ-036 rst SHALL preset synchronizer and history flops to ser_clk=0, ser_dat=0, ser_pen=1, ser_clrn=1, so no false edge or clear follows reset.

Verification
REQ-037 Shift 64 bits of 0xDEADBEEF01234567 MSB first, then raise ser_pen -> frame_data=0xDEADBEEF01234567 and frame_valid=1 exactly SYNC_STAGES+2 cycles after the pen edge; frame_err=0; bit_cnt=0.
REQ-038 Shift 63 bits, raise ser_pen -> frame_err=1, frame_valid=0, frame_data=0, bit_cnt=0; shift 70 bits -> bit_cnt reads 65 before the latch.
REQ-039 Good frame 0x1 then good frame 0x2 without ack -> frame_data=0x2, frame_valid=1, overrun=1; then ack one cycle -> frame_valid=0 next cycle, overrun still 1.
REQ-040 Shift 40 bits, hold ser_clrn low 4 cycles, then shift 64 ones and latch -> frame_data=0xFFFFFFFFFFFFFFFF, frame_err=0.
REQ-041 Assert rst one cycle after 32 bits -> all outputs 0; a following full frame 0x0123456789ABCDEF is received correctly.
REQ-042 frame_ack in the same cycle as LATCH of frame 0x5, with 0x4 pending -> frame_data=0x5, frame_valid=1, overrun=0.

Source files
------------

// File: rtl/seg_serial_rx.sv
// Receiving end of the serial display/LED shift link: synchronizes the pins, shifts bits in MSB
// first and publishes each correctly sized frame on the rising edge of the latch enable.
module seg_serial_rx #(
    parameter int unsigned FRAME_BITS  = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ser_clk,
    input  logic                          ser_dat,
    input  logic                          ser_pen,
    input  logic                          ser_clrn,
    input  logic                          frame_ack,
    output logic [FRAME_BITS-1:0]         frame_data,
    output logic                          frame_valid,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FRAME_BITS):0]   bit_cnt
);

    localparam int unsigned CW = $clog2(FRAME_BITS) + 1;
    localparam logic [CW-1:0] CntFull = CW'(FRAME_BITS);
    localparam logic [CW-1:0] CntSat  = CW'(FRAME_BITS + 1);
    // Pin order {clrn, pen, dat, clk}; idle values keep reset from looking like an edge or clear.
    localparam logic [3:0] PinIdle = 4'b1100;

    typedef enum logic [1:0] {StIdle, StShift, StLatch} state_e;

    state_e                         state_q;
    logic [SYNC_STAGES-1:0][3:0]    sync_q;
    logic [1:0]                     hist_q;   // {pen, clk}
    logic [FRAME_BITS-1:0]          shift_q;

    logic [3:0] pins_s;
    logic       clk_rise;
    logic       pen_rise;
    logic       shift_ev;
    logic       clr_act;

    assign pins_s   = sync_q[SYNC_STAGES-1];
    assign clk_rise = pins_s[0] & ~hist_q[0];
    assign pen_rise = pins_s[2] & ~hist_q[1];
    assign shift_ev = clk_rise & ~pins_s[2];
    assign clr_act  = ~pins_s[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= {SYNC_STAGES{PinIdle}};
            hist_q      <= 2'b10;
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_cnt     <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {ser_clrn, ser_pen, ser_dat, ser_clk}};
            hist_q <= {pins_s[2], pins_s[0]};

            // A latch below in the same cycle re-asserts valid, overriding the ack.
            if (frame_ack && frame_valid) begin
                frame_valid <= 1'b0;
            end

            if (clr_act) begin
                shift_q <= '0;
                bit_cnt <= '0;
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (shift_ev) begin
                            shift_q <= {shift_q[FRAME_BITS-2:0], pins_s[1]};
                            bit_cnt <= CW'(1);
                            state_q <= StShift;
                        end
                    end
                    StShift: begin
                        if (pen_rise) begin
                            state_q <= StLatch;
                        end else if (shift_ev) begin
                            shift_q <= {shift_q[FRAME_BITS-2:0], pins_s[1]};
                            if (bit_cnt != CntSat) begin
                                bit_cnt <= bit_cnt + CW'(1);
                            end
                        end
                    end
                    StLatch: begin
                        if (bit_cnt == CntFull) begin
                            frame_data  <= shift_q;
                            frame_valid <= 1'b1;
                            if (frame_valid && !frame_ack) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                        shift_q <= '0;
                        bit_cnt <= '0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule
